// File: rtl/uart_receiver_if.sv
// uart_receiver_if: byte-side handshake between the UART receiver and its consumer.
//   rx_data   received byte (receiver -> consumer)
//   rx_valid  rx_data holds an unread byte
//   frame_err one-clk pulse, stop bit sampled low
//   overrun   sticky, a byte was dropped because the previous one was unread
//   rx_ack    consumer acknowledge (consumer -> receiver)
// master = receiver side, slave = consumer side.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun
  );

  modport slave (
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with 16x oversampling and 3-sample majority vote.
// Received bytes are held in a one-deep buffer with a valid/ack handshake.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous reset, active high
//   RxD  in  serial line, idle high, asynchronous to clk
//   rx   uart_receiver_if.master: rx_ack in; rx_data, rx_valid, frame_err, overrun out
// Parameters:
//   TICK_DIV   clk cycles per oversample tick (>= 2)
//   DATA_BITS  data bits per frame, LSB first
module uart_receiver #(
  parameter int TICK_DIV  = 27,
  parameter int DATA_BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RxD,
  uart_receiver_if.master rx
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state_reg;
  logic                 sync1_reg;
  logic                 sync2_reg;
  logic [PW-1:0]        presc_reg;
  logic [3:0]           tick_cnt_reg;
  logic [BW-1:0]        bit_cnt_reg;
  logic                 s7_reg;
  logic                 s8_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 deliver_reg;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rx_valid_reg;
  logic                 frame_err_reg;
  logic                 overrun_reg;

  logic rxs;
  logic tick;
  logic vote;
  logic at_t9;
  logic at_t15;

  // Two-flop synchroniser; idles high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= RxD;
      sync2_reg <= sync1_reg;
    end
  end

  assign rxs    = sync2_reg;
  assign tick   = (presc_reg == PRESC_LAST);
  // Samples from ticks 7 and 8 are stored; the third sample is the live line at tick 9.
  assign vote   = (s7_reg & s8_reg) | (s7_reg & rxs) | (s8_reg & rxs);
  assign at_t9  = tick && (tick_cnt_reg == 4'd9);
  assign at_t15 = tick && (tick_cnt_reg == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      presc_reg     <= '0;
      tick_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      s7_reg        <= 1'b1;
      s8_reg        <= 1'b1;
      shift_reg     <= '0;
      deliver_reg   <= 1'b0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      deliver_reg   <= 1'b0;

      // Oversample timebase runs only while a frame is in progress; the
      // 4-bit tick counter wraps naturally at the end of each bit period.
      if (state_reg != IDLE) begin
        if (tick) begin
          presc_reg    <= '0;
          tick_cnt_reg <= tick_cnt_reg + 4'd1;
        end else begin
          presc_reg <= presc_reg + PW'(1);
        end
      end

      if (tick && (tick_cnt_reg == 4'd7)) s7_reg <= rxs;
      if (tick && (tick_cnt_reg == 4'd8)) s8_reg <= rxs;

      case (state_reg)
        IDLE: begin
          if (!rxs) begin
            state_reg    <= START;
            presc_reg    <= '0;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
          end
        end
        START: begin
          if (at_t9 && vote) begin
            state_reg <= IDLE;          // glitch, not a real start bit
          end else if (at_t15) begin
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (at_t9) begin
            shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
          end
          if (at_t15) begin
            if (bit_cnt_reg == BIT_LAST) begin
              state_reg   <= STOP;
              bit_cnt_reg <= '0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BW'(1);
            end
          end
        end
        STOP: begin
          // Leave at mid-stop so the next start edge has half a bit of slack.
          if (at_t9) begin
            if (vote) begin
              deliver_reg <= 1'b1;
              state_reg   <= IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rxs) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      // One-deep output buffer. An ack landing on the delivery clk lets the
      // new byte replace the old one without ever dropping rx_valid.
      if (deliver_reg) begin
        if (!rx_valid_reg) begin
          rx_data_reg  <= shift_reg;
          rx_valid_reg <= 1'b1;
        end else if (rx.rx_ack) begin
          rx_data_reg <= shift_reg;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (rx_valid_reg && rx.rx_ack) begin
        rx_valid_reg <= 1'b0;
        overrun_reg  <= 1'b0;
      end
    end
  end

  assign rx.rx_data   = rx_data_reg;
  assign rx.rx_valid  = rx_valid_reg;
  assign rx.frame_err = frame_err_reg;
  assign rx.overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  logic clk = 1'b0;
  logic rst;
  logic rxd;

  uart_receiver_if #(.DATA_BITS(8)) bus ();

  uart_receiver #(
    .TICK_DIV (TICK_DIV),
    .DATA_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .RxD(rxd),
    .rx (bus.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int lat      = 0;

  // frame_err pulse monitor
  int   ferr_pulses = 0;
  int   ferr_run    = 0;
  int   ferr_max    = 0;
  logic ferr_prev   = 1'b0;

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) begin
      ferr_run <= ferr_run + 1;
      if (ferr_run + 1 > ferr_max) ferr_max <= ferr_run + 1;
      if (!ferr_prev) ferr_pulses <= ferr_pulses + 1;
    end else begin
      ferr_run <= 0;
    end
    ferr_prev <= (bus.frame_err === 1'b1);
  end

  // Reference model of the consumer-visible state
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_overrun;
  int         m_ferr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_deliver(input logic [7:0] b, input logic acked);
    if (!m_valid) begin
      m_data  = b;
      m_valid = 1'b1;
    end else if (acked) begin
      m_data = b;
    end else begin
      m_overrun = 1'b1;
    end
  endtask

  task automatic model_ack();
    if (m_valid) begin
      m_valid   = 1'b0;
      m_overrun = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".valid"},   bus.rx_valid, m_valid);
    check_eq({tag, ".data"},    bus.rx_data,  m_data);
    check_eq({tag, ".overrun"}, bus.overrun,  m_overrun);
    check_eq({tag, ".ferrs"},   ferr_pulses,  m_ferr);
    $display("txn %-12s valid=%0b data=%02h overrun=%0b ferr_pulses=%0d",
             tag, bus.rx_valid, bus.rx_data, bus.overrun, ferr_pulses);
  endtask

  // Serial line driver: start, 8 data bits LSB first, stop.
  // A bad stop bit holds the line low for low_hold clks, then high for one bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int low_hold);
    @(posedge clk);
    rxd = 1'b0;
    repeat (BIT_CLKS) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_CLKS) @(posedge clk);
    end
    if (stop_ok) begin
      rxd = 1'b1;
      repeat (BIT_CLKS) @(posedge clk);
    end else begin
      rxd = 1'b0;
      repeat (low_hold) @(posedge clk);
      rxd = 1'b1;
      repeat (BIT_CLKS) @(posedge clk);
    end
  endtask

  task automatic send_good(input logic [7:0] b, input string tag);
    send_frame(b, 1'b1, 0);
    @(negedge clk);
    model_deliver(b, 1'b0);
    check_state(tag);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    model_ack();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    rxd        = 1'b1;
    bus.rx_ack = 1'b0;
    m_valid    = 1'b0;
    m_data     = 8'h00;
    m_overrun  = 1'b0;
    m_ferr     = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.valid",     bus.rx_valid,  1'b0);
    check_eq("reset.data",      bus.rx_data,   8'h00);
    check_eq("reset.frame_err", bus.frame_err, 1'b0);
    check_eq("reset.overrun",   bus.overrun,   1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 1: 0xA5, measure start-edge to rx_valid latency, then ack
    fork
      send_frame(8'hA5, 1'b1, 0);
      begin
        @(posedge clk);
        lat = 0;
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          if (bus.rx_valid === 1'b1) break;
          @(posedge clk);
          lat++;
        end
      end
    join
    $display("txn t1 latency=%0d clks", lat);
    check_eq("t1.latency_in_window", (lat >= 604 && lat <= 640), 1'b1);
    @(negedge clk);
    model_deliver(8'hA5, 1'b0);
    check_state("t1_rx");
    ack_pulse();
    check_state("t1_ack");

    // 2: short low glitch is a false start, then 0x3C
    @(negedge clk);
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (120) @(negedge clk);
    check_state("t2_glitch");
    send_good(8'h3C, "t2_rx");
    ack_pulse();

    // 3: bad stop bit held low, then 0x81
    send_frame(8'h55, 1'b0, 200);
    @(negedge clk);
    m_ferr++;
    check_state("t3_ferr");
    check_eq("t3.ferr_width", ferr_max, 1);
    send_good(8'h81, "t3_rx");
    ack_pulse();

    // 4: two bytes without ack -> overrun, first byte kept
    send_good(8'h11, "t4_first");
    send_good(8'h22, "t4_overrun");
    ack_pulse();
    check_state("t4_ack");

    // 5: ack on exactly the delivery clk of the second byte
    send_good(8'h66, "t5_first");
    @(negedge clk);
    fork
      send_frame(8'h77, 1'b1, 0);
      begin
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        @(negedge clk);
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
      end
    join
    @(negedge clk);
    model_deliver(8'h77, 1'b1);
    check_state("t5_same_clk");
    ack_pulse();
    check_state("t5_ack");

    // Randomised traffic: bytes, occasional bad stop bits, random acks and gaps
    for (int n = 0; n < 12; n++) begin
      logic [7:0] b;
      bit         bad;
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      if (bad) begin
        send_frame(b, 1'b0, int'($urandom_range(70, 200)));
        @(negedge clk);
        m_ferr++;
      end else begin
        send_frame(b, 1'b1, 0);
        @(negedge clk);
        model_deliver(b, 1'b0);
      end
      $display("txn rand%0d byte=%02h bad_stop=%0b", n, b, bad);
      check_state("rand_rx");
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        check_state("rand_ack");
      end
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end

    // 6: reset during data bit 4 of 0xF0 with a byte pending
    send_good(8'hC3, "t6_pending");
    @(negedge clk);
    fork
      send_frame(8'hF0, 1'b1, 0);
      begin
        @(posedge clk);
        repeat (5 * BIT_CLKS + 32) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6.rst_valid",   bus.rx_valid,  1'b0);
        check_eq("t6.rst_data",    bus.rx_data,   8'h00);
        check_eq("t6.rst_overrun", bus.overrun,   1'b0);
        check_eq("t6.rst_ferr",    bus.frame_err, 1'b0);
        m_valid   = 1'b0;
        m_data    = 8'h00;
        m_overrun = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
      end
    join
    repeat (30) @(negedge clk);
    check_state("t6_after");
    send_good(8'h0F, "t6_rx");
    ack_pulse();
    check_state("t6_ack");

    if (ferr_pulses > 0) check_eq("final.ferr_width", ferr_max, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
